lm32_dp_ram_ctrl: RTL and testbench

- Front-end controller for a 1-write/1-read dual-port RAM with a registered read address.
- Multiplexes two write requesters onto the write port and two read requesters onto the read port, each with independent round-robin arbitration.
- After reset, or on flush_i, sweeps every RAM location to INIT_VALUE before accepting traffic. This is the usual cache-tag/valid-array invalidation sequence.
- Sits between cache/MMU logic and the RAM instance; the RAM instance lives outside this block.

---
 rtl/lm32_dp_ram_ctrl_pkg.sv | 13 +
 rtl/lm32_rr_arb2.sv | 34 +++
 rtl/lm32_dp_ram_ctrl.sv | 134 +++++++++++++
 tb/tb_lm32_dp_ram_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lm32_dp_ram_ctrl_pkg.sv
// Shared definitions for the dual-port RAM front-end controller.
// Holds the FSM state encoding and the requester index constants.
package lm32_dp_ram_ctrl_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

endpackage

// File: rtl/lm32_rr_arb2.sv
// Two-way round-robin arbiter. The pointer always moves to the requester that
// did not win, so a contended pair alternates and a lone winner yields next time.
module lm32_rr_arb2
    import lm32_dp_ram_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        grant_o = 2'b00;
        ptr_d   = ptr_q;
        if (en_i && (|req_i)) begin
            if (&req_i) begin
                if (ptr_q) grant_o[REQ1] = 1'b1;
                else       grant_o[REQ0] = 1'b1;
            end else begin
                grant_o = req_i;
            end
            ptr_d = grant_o[REQ0];  // point at the loser
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/lm32_dp_ram_ctrl.sv
// Front-end for a 1W/1R RAM with registered read address: arbitrates two
// writers and two readers, and sweeps the array to INIT_VALUE after reset/flush.
module lm32_dp_ram_ctrl
    import lm32_dp_ram_ctrl_pkg::*;
#(
    parameter int                    addr_width = 10,
    parameter int                    addr_depth = 1024,
    parameter int                    data_width = 8,
    parameter logic [data_width-1:0] INIT_VALUE = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    input  logic                  wr0_req_i,
    input  logic [addr_width-1:0] wr0_addr_i,
    input  logic [data_width-1:0] wr0_data_i,
    output logic                  wr0_ack_o,
    input  logic                  wr1_req_i,
    input  logic [addr_width-1:0] wr1_addr_i,
    input  logic [data_width-1:0] wr1_data_i,
    output logic                  wr1_ack_o,
    input  logic                  rd0_req_i,
    input  logic [addr_width-1:0] rd0_addr_i,
    output logic                  rd0_ack_o,
    output logic                  rd0_valid_o,
    input  logic                  rd1_req_i,
    input  logic [addr_width-1:0] rd1_addr_i,
    output logic                  rd1_ack_o,
    output logic                  rd1_valid_o,
    output logic [data_width-1:0] rd_data_o,
    output logic                  ram_we_o,
    output logic [addr_width-1:0] ram_waddr_o,
    output logic [data_width-1:0] ram_wdata_o,
    output logic [addr_width-1:0] ram_raddr_o,
    input  logic [data_width-1:0] ram_rdata_i
);

    localparam logic [addr_width-1:0] LAST = addr_width'(addr_depth - 1);

    state_e                state_q;
    logic [addr_width-1:0] cnt_q;
    logic [1:0]            rd_valid_q, rd_valid_d;
    logic [1:0]            wr_gnt, rd_gnt;
    logic                  arb_en;

    // Traffic is only served in IDLE; a flush cycle grants nothing.
    assign arb_en = !rst_i && (state_q == ST_IDLE) && !flush_i;

    lm32_rr_arb2 u_wr_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (arb_en),
        .req_i   ({wr1_req_i, wr0_req_i}),
        .grant_o (wr_gnt)
    );

    lm32_rr_arb2 u_rd_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (arb_en),
        .req_i   ({rd1_req_i, rd0_req_i}),
        .grant_o (rd_gnt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (flush_i) begin
                        cnt_q <= '0;
                    end else if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (flush_i) begin
                        cnt_q   <= '0;
                        state_q <= ST_CLEAR;
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    always_comb begin
        ram_we_o    = 1'b0;
        ram_waddr_o = '0;
        ram_wdata_o = '0;
        if (!rst_i && (state_q == ST_CLEAR)) begin
            ram_we_o    = 1'b1;
            ram_waddr_o = cnt_q;
            ram_wdata_o = INIT_VALUE;
        end else if (wr_gnt[REQ0]) begin
            ram_we_o    = 1'b1;
            ram_waddr_o = wr0_addr_i;
            ram_wdata_o = wr0_data_i;
        end else if (wr_gnt[REQ1]) begin
            ram_we_o    = 1'b1;
            ram_waddr_o = wr1_addr_i;
            ram_wdata_o = wr1_data_i;
        end
    end

    always_comb begin
        ram_raddr_o = '0;
        if (rd_gnt[REQ0])      ram_raddr_o = rd0_addr_i;
        else if (rd_gnt[REQ1]) ram_raddr_o = rd1_addr_i;
    end

    assign rd_valid_d = rd_gnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rd_valid_q <= 2'b00;
        else       rd_valid_q <= rd_valid_d;
    end

    assign busy_o      = rst_i || (state_q == ST_CLEAR);
    assign wr0_ack_o   = wr_gnt[REQ0];
    assign wr1_ack_o   = wr_gnt[REQ1];
    assign rd0_ack_o   = rd_gnt[REQ0];
    assign rd1_ack_o   = rd_gnt[REQ1];
    assign rd0_valid_o = rd_valid_q[REQ0];
    assign rd1_valid_o = rd_valid_q[REQ1];
    assign rd_data_o   = ram_rdata_i;

endmodule

// File: tb/tb_lm32_dp_ram_ctrl.sv
// Directed bench for lm32_dp_ram_ctrl with a 16x8 registered-read RAM model.
module tb_lm32_dp_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_i, flush_i, busy_o;
    logic       wr0_req_i, wr1_req_i, wr0_ack_o, wr1_ack_o;
    logic [3:0] wr0_addr_i, wr1_addr_i;
    logic [7:0] wr0_data_i, wr1_data_i;
    logic       rd0_req_i, rd1_req_i, rd0_ack_o, rd1_ack_o, rd0_valid_o, rd1_valid_o;
    logic [3:0] rd0_addr_i, rd1_addr_i;
    logic [7:0] rd_data_o;
    logic       ram_we_o;
    logic [3:0] ram_waddr_o, ram_raddr_o;
    logic [7:0] ram_wdata_o, ram_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lm32_dp_ram_ctrl #(
        .addr_width (4),
        .addr_depth (16),
        .data_width (8),
        .INIT_VALUE (8'hA5)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .wr0_req_i   (wr0_req_i),
        .wr0_addr_i  (wr0_addr_i),
        .wr0_data_i  (wr0_data_i),
        .wr0_ack_o   (wr0_ack_o),
        .wr1_req_i   (wr1_req_i),
        .wr1_addr_i  (wr1_addr_i),
        .wr1_data_i  (wr1_data_i),
        .wr1_ack_o   (wr1_ack_o),
        .rd0_req_i   (rd0_req_i),
        .rd0_addr_i  (rd0_addr_i),
        .rd0_ack_o   (rd0_ack_o),
        .rd0_valid_o (rd0_valid_o),
        .rd1_req_i   (rd1_req_i),
        .rd1_addr_i  (rd1_addr_i),
        .rd1_ack_o   (rd1_ack_o),
        .rd1_valid_o (rd1_valid_o),
        .rd_data_o   (rd_data_o),
        .ram_we_o    (ram_we_o),
        .ram_waddr_o (ram_waddr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_raddr_o (ram_raddr_o),
        .ram_rdata_i (ram_rdata_i)
    );

    // External RAM: write on the edge, read address registered on the same edge.
    logic [7:0] mem [16];
    logic [3:0] raddr_q;
    always @(posedge clk) begin
        if (ram_we_o) mem[ram_waddr_o] <= ram_wdata_o;
        raddr_q <= ram_raddr_o;
    end
    assign ram_rdata_i = mem[raddr_q];

    task automatic test_reset();
        @(negedge clk);
        wr0_req_i = 1'b1; wr0_addr_i = 4'd1; wr0_data_i = 8'h01;
        rd1_req_i = 1'b1; rd1_addr_i = 4'd2;
        #1;
        n_tests++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b exp 1", busy_o); end
        n_tests++; if (ram_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", ram_we_o); end
        n_tests++; if ({wr0_ack_o, rd1_ack_o} !== 2'b00) begin n_fail++; $display("FAIL reset_acks got %b exp 00", {wr0_ack_o, rd1_ack_o}); end
        @(negedge clk); #1;
        n_tests++; if ({rd0_valid_o, rd1_valid_o} !== 2'b00) begin n_fail++; $display("FAIL reset_valid got %b exp 00", {rd0_valid_o, rd1_valid_o}); end
        wr0_req_i = 1'b0; rd1_req_i = 1'b0;
    endtask

    // Sweep after reset, with rd0 (addr 7) held the whole time.
    task automatic test_clear();
        @(negedge clk);
        rst_i = 1'b0;
        rd0_req_i = 1'b1; rd0_addr_i = 4'd7;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_tests++;
            if (busy_o !== 1'b1 || ram_we_o !== 1'b1 || ram_waddr_o !== 4'(i) || ram_wdata_o !== 8'hA5 || rd0_ack_o !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_cycle%0d got busy=%b we=%b waddr=%h wdata=%h ack=%b exp 1 1 %h a5 0",
                         i, busy_o, ram_we_o, ram_waddr_o, ram_wdata_o, rd0_ack_o, 4'(i));
            end
            @(negedge clk);
        end
        #1;
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL clear_done_busy got %b exp 0", busy_o); end
        n_tests++; if (rd0_ack_o !== 1'b1 || ram_raddr_o !== 4'd7) begin n_fail++; $display("FAIL rd_ack got ack=%b raddr=%h exp 1 7", rd0_ack_o, ram_raddr_o); end
        @(negedge clk);
        rd0_req_i = 1'b0;
        #1;
        n_tests++; if (rd0_valid_o !== 1'b1 || rd_data_o !== 8'hA5) begin n_fail++; $display("FAIL rd_valid got valid=%b data=%h exp 1 a5", rd0_valid_o, rd_data_o); end
        n_tests++; if (rd0_ack_o !== 1'b0) begin n_fail++; $display("FAIL rd_ack_drop got %b exp 0", rd0_ack_o); end
        @(negedge clk); #1;
        n_tests++; if (rd0_valid_o !== 1'b0) begin n_fail++; $display("FAIL rd_valid_once got %b exp 0", rd0_valid_o); end
        n_tests++; if (ram_we_o !== 1'b0 || ram_raddr_o !== 4'd0 || ram_waddr_o !== 4'd0) begin n_fail++; $display("FAIL idle_outs got we=%b raddr=%h waddr=%h exp 0 0 0", ram_we_o, ram_raddr_o, ram_waddr_o); end
    endtask

    task automatic test_wr_alternate();
        logic [3:0] ea;
        logic [7:0] ed;
        @(negedge clk);
        wr0_req_i = 1'b1; wr0_addr_i = 4'd3; wr0_data_i = 8'h11;
        wr1_req_i = 1'b1; wr1_addr_i = 4'd4; wr1_data_i = 8'h22;
        for (int k = 0; k < 4; k++) begin
            ea = (k % 2 == 0) ? 4'd3 : 4'd4;
            ed = (k % 2 == 0) ? 8'h11 : 8'h22;
            #1;
            n_tests++;
            if (ram_we_o !== 1'b1 || wr0_ack_o !== (k % 2 == 0) || wr1_ack_o !== (k % 2 == 1) || ram_waddr_o !== ea || ram_wdata_o !== ed) begin
                n_fail++;
                $display("FAIL wr_alt%0d got we=%b ack0=%b ack1=%b waddr=%h wdata=%h exp waddr=%h wdata=%h",
                         k, ram_we_o, wr0_ack_o, wr1_ack_o, ram_waddr_o, ram_wdata_o, ea, ed);
            end
            @(negedge clk);
        end
        wr0_req_i = 1'b0; wr1_req_i = 1'b0;
    endtask

    task automatic test_rw_same_addr();
        wr0_req_i = 1'b1; wr0_addr_i = 4'd5; wr0_data_i = 8'h3C;
        rd1_req_i = 1'b1; rd1_addr_i = 4'd5;
        #1;
        n_tests++; if (wr0_ack_o !== 1'b1 || rd1_ack_o !== 1'b1 || ram_raddr_o !== 4'd5 || ram_waddr_o !== 4'd5) begin
            n_fail++; $display("FAIL rw_acks got w=%b r=%b raddr=%h waddr=%h exp 1 1 5 5", wr0_ack_o, rd1_ack_o, ram_raddr_o, ram_waddr_o); end
        @(negedge clk);
        wr0_req_i = 1'b0; rd1_req_i = 1'b0;
        #1;
        n_tests++; if (rd1_valid_o !== 1'b1 || rd0_valid_o !== 1'b0 || rd_data_o !== 8'h3C) begin
            n_fail++; $display("FAIL rw_data got v1=%b v0=%b data=%h exp 1 0 3c", rd1_valid_o, rd0_valid_o, rd_data_o); end
    endtask

    // rd pointer is at rd0 here (rd0 then rd1 each won alone).
    task automatic test_back_to_back_reads();
        @(negedge clk);
        rd0_req_i = 1'b1; rd0_addr_i = 4'd3;
        rd1_req_i = 1'b1; rd1_addr_i = 4'd4;
        #1;
        n_tests++; if (rd0_ack_o !== 1'b1 || rd1_ack_o !== 1'b0 || ram_raddr_o !== 4'd3) begin
            n_fail++; $display("FAIL b2b_first got a0=%b a1=%b raddr=%h exp 1 0 3", rd0_ack_o, rd1_ack_o, ram_raddr_o); end
        @(negedge clk); #1;
        n_tests++; if (rd1_ack_o !== 1'b1 || rd0_ack_o !== 1'b0 || ram_raddr_o !== 4'd4) begin
            n_fail++; $display("FAIL b2b_second got a0=%b a1=%b raddr=%h exp 0 1 4", rd0_ack_o, rd1_ack_o, ram_raddr_o); end
        n_tests++; if (rd0_valid_o !== 1'b1 || rd_data_o !== 8'h11) begin
            n_fail++; $display("FAIL b2b_data0 got v0=%b data=%h exp 1 11", rd0_valid_o, rd_data_o); end
        @(negedge clk);
        rd0_req_i = 1'b0; rd1_req_i = 1'b0;
        #1;
        n_tests++; if (rd1_valid_o !== 1'b1 || rd0_valid_o !== 1'b0 || rd_data_o !== 8'h22) begin
            n_fail++; $display("FAIL b2b_data1 got v1=%b v0=%b data=%h exp 1 0 22", rd1_valid_o, rd0_valid_o, rd_data_o); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        flush_i = 1'b1;
        wr1_req_i = 1'b1; wr1_addr_i = 4'd9; wr1_data_i = 8'h77;
        #1;
        n_tests++; if (busy_o !== 1'b0 || wr1_ack_o !== 1'b0 || ram_we_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_cycle got busy=%b ack=%b we=%b exp 0 0 0", busy_o, wr1_ack_o, ram_we_o); end
        @(negedge clk);
        flush_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_tests++;
            if (busy_o !== 1'b1 || ram_we_o !== 1'b1 || ram_waddr_o !== 4'(i) || ram_wdata_o !== 8'hA5 || wr1_ack_o !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_sweep%0d got busy=%b we=%b waddr=%h wdata=%h ack=%b exp 1 1 %h a5 0",
                         i, busy_o, ram_we_o, ram_waddr_o, ram_wdata_o, wr1_ack_o, 4'(i));
            end
            @(negedge clk);
        end
        #1;
        n_tests++; if (busy_o !== 1'b0 || wr1_ack_o !== 1'b1 || ram_waddr_o !== 4'd9 || ram_wdata_o !== 8'h77) begin
            n_fail++; $display("FAIL flush_done got busy=%b ack=%b waddr=%h wdata=%h exp 0 1 9 77", busy_o, wr1_ack_o, ram_waddr_o, ram_wdata_o); end
        @(negedge clk);
        wr1_req_i = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        #1;
        n_tests++; if (ram_waddr_o !== 4'd9) begin n_fail++; $display("FAIL mid_cnt got %h exp 9", ram_waddr_o); end
        rst_i = 1'b1;
        #1;
        n_tests++; if (ram_we_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL mid_rst got we=%b busy=%b exp 0 1", ram_we_o, busy_o); end
        @(negedge clk);
        rst_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_tests++;
            if (busy_o !== 1'b1 || ram_we_o !== 1'b1 || ram_waddr_o !== 4'(i)) begin
                n_fail++; $display("FAIL restart%0d got busy=%b we=%b waddr=%h exp 1 1 %h", i, busy_o, ram_we_o, ram_waddr_o, 4'(i));
            end
            @(negedge clk);
        end
        #1;
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL restart_done got %b exp 0", busy_o); end
    endtask

    task automatic test_reset_clears_valid();
        @(negedge clk);
        rd0_req_i = 1'b1; rd0_addr_i = 4'd2;
        @(negedge clk);
        rd0_req_i = 1'b0;
        #1;
        n_tests++; if (rd0_valid_o !== 1'b1) begin n_fail++; $display("FAIL pre_rst_valid got %b exp 1", rd0_valid_o); end
        rst_i = 1'b1;
        #1;
        n_tests++; if (rd0_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", rd0_valid_o); end
        @(negedge clk);
        rst_i = 1'b0;
        for (int i = 0; i < 16; i++) @(negedge clk);
        #1;
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid_sweep got %b exp 0", busy_o); end
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0;
        wr0_req_i = 1'b0; wr0_addr_i = '0; wr0_data_i = '0;
        wr1_req_i = 1'b0; wr1_addr_i = '0; wr1_data_i = '0;
        rd0_req_i = 1'b0; rd0_addr_i = '0;
        rd1_req_i = 1'b0; rd1_addr_i = '0;
        test_reset();
        test_clear();
        test_wr_alternate();
        test_rw_same_addr();
        test_back_to_back_reads();
        test_flush();
        test_reset_mid_sweep();
        test_reset_clears_valid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
